rx_bit_sampler: RTL and testbench

RX_BIT_SAMPLER -- requirements
Module: rx_bit_sampler

---
 rtl/rx_bit_sampler.sv | 119 +++++++++++
 tb/tb_rx_bit_sampler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_bit_sampler.sv
// Oversampled UART receive front end: synchronises rx_in, confirms the start bit at mid-bit,
// then strobes each data/parity bit and the stop bit on the 16x baud tick grid.
module rx_bit_sampler #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic baud_tick16,
  input  logic rx_in,
  output logic rx_start,
  output logic start_check,
  output logic rx_data_signal,
  output logic rx_bit,
  output logic stop_check,
  output logic frame_done,
  output logic framing_err,
  output logic busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [3:0] MID_TICK = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] END_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS);

  state_t     state;
  logic [3:0] tick_cnt;
  logic [3:0] bit_cnt;
  logic       rx_m;
  logic       rx_s;
  logic       rx_bit_q;
  logic       mid_tick;
  logic       end_tick;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_in;
      rx_s <= rx_m;
    end
  end

  assign mid_tick = baud_tick16 && (tick_cnt == MID_TICK);
  assign end_tick = baud_tick16 && (tick_cnt == END_TICK);

  // Pulses are decoded in the tick cycle itself so they never appear on a tick-less clock.
  assign rx_start       = (state == START) && mid_tick && !rx_s;
  assign rx_data_signal = (state == DATA) && end_tick;
  assign frame_done     = (state == STOP) && end_tick;
  assign framing_err    = frame_done && !rx_s;
  assign rx_bit         = rx_data_signal ? rx_s : rx_bit_q;
  assign busy           = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tick_cnt    <= 4'd0;
      bit_cnt     <= 4'd0;
      start_check <= 1'b0;
      rx_bit_q    <= 1'b0;
      stop_check  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            tick_cnt <= 4'd0;
          end
        end
        START: begin
          if (baud_tick16) begin
            if (tick_cnt == MID_TICK) begin
              tick_cnt <= 4'd0;
              if (!rx_s) begin
                start_check <= 1'b1;
                bit_cnt     <= 4'd0;
                state       <= DATA;
              end else begin
                state <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (baud_tick16) begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == END_TICK) begin
              rx_bit_q <= rx_s;
              bit_cnt  <= bit_cnt + 4'd1;
              // bit_cnt == DATA_BITS here means the parity bit was just sampled
              if (bit_cnt == LAST_BIT) begin
                state    <= STOP;
                tick_cnt <= 4'd0;
              end
            end
          end
        end
        STOP: begin
          if (baud_tick16) begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == END_TICK) begin
              stop_check  <= rx_s;
              start_check <= 1'b0;
              tick_cnt    <= 4'd0;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_bit_sampler.sv
// Directed bench for rx_bit_sampler: clean, glitch, framing-error, reset-abort,
// back-to-back and slow-tick frames.
module tb_rx_bit_sampler;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic baud_tick16 = 1'b0;
  logic rx_in = 1'b1;
  logic rx_start, start_check, rx_data_signal, rx_bit;
  logic stop_check, frame_done, framing_err, busy;

  int n_checks = 0;
  int n_errors = 0;

  int tick_div = 1;
  int tick_phase = 0;
  int cyc = 0;

  int   n_start = 0;
  int   n_done = 0;
  int   n_ferr = 0;
  int   busy_cycles = 0;
  int   proto_err = 0;
  int   last_ev = 0;
  logic done_prev = 1'b0;
  logic bit_q[$];
  int   gap_q[$];

  rx_bit_sampler #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .baud_tick16    (baud_tick16),
    .rx_in          (rx_in),
    .rx_start       (rx_start),
    .start_check    (start_check),
    .rx_data_signal (rx_data_signal),
    .rx_bit         (rx_bit),
    .stop_check     (stop_check),
    .frame_done     (frame_done),
    .framing_err    (framing_err),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc++;
    #1;
    baud_tick16 = (tick_phase == 0);
    tick_phase  = (tick_phase + 1 >= tick_div) ? 0 : tick_phase + 1;
  end

  // Event log, sampled on the falling edge.
  always @(negedge clock) begin
    int np;
    np = int'(rx_start) + int'(rx_data_signal) + int'(frame_done);
    if (np > 1 || (framing_err && !frame_done) || (np > 0 && !baud_tick16))
      proto_err++;
    if (done_prev && busy) proto_err++;
    done_prev = frame_done;
    if (busy) busy_cycles++;
    if (rx_start) begin
      n_start++;
      last_ev = cyc;
    end
    if (rx_data_signal) begin
      bit_q.push_back(rx_bit);
      gap_q.push_back(cyc - last_ev);
      last_ev = cyc;
    end
    if (frame_done) begin
      n_done++;
      if (framing_err) n_ferr++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bits_since(input int s, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++)
      if (s + i < bit_q.size()) v[i] = bit_q[s + i];
    return v;
  endfunction

  function automatic int gap_at(input int i);
    return (i < gap_q.size()) ? gap_q[i] : -1;
  endfunction

  function automatic int gap_bad(input int s, input int exp);
    int bad;
    bad = 0;
    for (int i = s; i < gap_q.size(); i++)
      if (gap_q[i] != exp) bad++;
    return bad;
  endfunction

  task automatic drive_bit(input logic b, input int n);
    rx_in = b;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int gap);
    int per;
    per = 16 * tick_div;
    drive_bit(1'b0, per);
    for (int i = 0; i < 8; i++) drive_bit(d[i], per);
    drive_bit(par, per);
    rx_in = stp;
    for (int i = 0; i < per * 4; i++) begin
      @(negedge clock);
      if (frame_done) break;
    end
    @(posedge clock);
    #1;
    rx_in = 1'b1;
    if (gap > 0) begin
      repeat (gap) @(posedge clock);
      #1;
    end
  endtask

  int sb, sg, st, dn, fe, bc;
  logic [7:0] d5 = 8'h5A;

  task automatic snap();
    sb = bit_q.size();
    sg = gap_q.size();
    st = n_start;
    dn = n_done;
    fe = n_ferr;
    bc = busy_cycles;
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outs", 32'({rx_start, start_check, rx_data_signal, rx_bit,
                             frame_done, framing_err, busy, stop_check}), 32'h01);
    reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;

    // 0xA5, even parity 0, stop 1, tick every clock
    snap();
    send_frame(8'hA5, 1'b0, 1'b1, 10);
    check("a5_start",    n_start - st, 1);
    check("a5_strobes",  bit_q.size() - sb, 9);
    check("a5_bits",     bits_since(sb, 9), 32'h0A5);
    check("a5_done",     n_done - dn, 1);
    check("a5_ferr",     n_ferr - fe, 0);
    check("a5_stop",     32'(stop_check), 1);
    check("a5_gap_first", gap_at(sg), 16);
    check("a5_gap_all",  gap_bad(sg, 16), 0);
    check("a5_idle",     32'({start_check, busy}), 0);

    // Glitch: 4 ticks low, then high again
    snap();
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 40);
    check("glitch_start",   n_start - st, 0);
    check("glitch_strobes", bit_q.size() - sb, 0);
    check("glitch_entered", 32'(busy_cycles > bc), 1);
    check("glitch_idle",    32'(busy), 0);

    // 0x3C with a zero stop bit
    snap();
    send_frame(8'h3C, 1'b0, 1'b0, 10);
    check("ferr_bits", bits_since(sb, 9), 32'h03C);
    check("ferr_done", n_done - dn, 1);
    check("ferr_err",  n_ferr - fe, 1);
    check("ferr_stop", 32'(stop_check), 0);

    // Reset after the 4th data strobe of a 0x5A frame
    snap();
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(d5[i], 16);
    check("rst_pre_strobes", bit_q.size() - sb, 4);
    check("rst_pre_state",   32'({start_check, busy, rx_bit}), 32'h7);
    reset = 1'b1;
    #1;
    check("rst_outs", 32'({rx_start, start_check, rx_data_signal, rx_bit,
                           frame_done, framing_err, busy, stop_check}), 32'h01);
    repeat (3) @(posedge clock);
    #1;
    rx_in = 1'b1;
    reset = 1'b0;
    repeat (30) @(posedge clock);
    #1;
    check("rst_no_done", n_done - dn, 0);
    snap();
    send_frame(8'h81, 1'b0, 1'b1, 10);
    check("post_rst_strobes", bit_q.size() - sb, 9);
    check("post_rst_bits",    bits_since(sb, 9), 32'h081);
    check("post_rst_done",    n_done - dn, 1);

    // Back-to-back 0xFF then 0x00, next start right after the stop sample
    snap();
    send_frame(8'hFF, 1'b0, 1'b1, 0);
    send_frame(8'h00, 1'b0, 1'b1, 10);
    check("b2b_start",   n_start - st, 2);
    check("b2b_strobes", bit_q.size() - sb, 18);
    check("b2b_bits",    bits_since(sb, 18), 32'h000FF);
    check("b2b_done",    n_done - dn, 2);
    check("b2b_gap_all", gap_bad(sg, 16), 0);

    // Tick every 3rd clock
    tick_div = 3;
    repeat (6) @(posedge clock);
    #1;
    snap();
    send_frame(8'hA5, 1'b0, 1'b1, 30);
    check("slow_strobes",   bit_q.size() - sb, 9);
    check("slow_bits",      bits_since(sb, 9), 32'h0A5);
    check("slow_gap_first", gap_at(sg), 48);
    check("slow_gap_all",   gap_bad(sg, 48), 0);
    check("slow_done",      n_done - dn, 1);
    check("slow_ferr",      n_ferr - fe, 0);

    check("protocol", proto_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
